// File: rtl/morse_player.sv
// Morse letter player: plays up to five short/long/gap symbols on tone,
// with unit-based mark/space timing, letter gap, done/err pulses and abort.
module morse_player #(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] code_in,
  input  logic       abort,
  output logic       ready,
  output logic       tone,
  output logic       done,
  output logic       err,
  output logic [2:0] sym_idx
);

  typedef enum logic [2:0] {IDLE, MARK, SPACE, LGAP, DONE} state_t;

  localparam logic [23:0] UNIT_LAST = 24'(UNIT_CYCLES - 1);

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;
  logic [2:0]  mult, mult_n;
  logic [2:0]  units, units_n;
  logic [2:0]  left, left_n;
  logic [2:0]  sym, sym_n;
  logic        skip, skip_n;
  logic [9:0]  code, code_n;
  logic [2:0]  lz;
  logic [9:0]  aligned;
  logic        accept, load, phase_end;
  logic [1:0]  ld;

  function automatic logic [2:0] lead_zeros(input logic [9:0] c);
    logic [2:0] n;
    logic       hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (c[2*i +: 2] != 2'b00) hit = 1'b1;
      if (!hit) n = n + 3'd1;
    end
    return n;
  endfunction

  assign lz        = lead_zeros(code_in);
  assign aligned   = code_in << {lz, 1'b0};
  assign ready     = (state == IDLE) || (state == DONE);
  assign done      = (state == DONE);
  assign err       = (state == SPACE) && skip;
  assign sym_idx   = sym;
  assign accept    = start && ready && !abort;
  // a skipped 01 symbol lasts exactly one cycle regardless of units
  assign phase_end = skip ||
                     ((cnt == UNIT_LAST) && (mult == units - 3'd1));

  // next-state: unit timing, symbol sequencing, accept and abort
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mult_n  = mult;
    units_n = units;
    skip_n  = skip;
    code_n  = code;
    left_n  = left;
    sym_n   = sym;
    load    = 1'b0;
    ld      = code[9:8];
    if (state == MARK || state == SPACE || state == LGAP) begin
      if (cnt == UNIT_LAST) begin
        cnt_n  = '0;
        mult_n = mult + 3'd1;
      end else begin
        cnt_n = cnt + 24'd1;
      end
    end
    unique case (state)
      IDLE: ;
      MARK:
        if (phase_end) begin
          state_n = SPACE;
          units_n = 3'd1;
          cnt_n   = '0;
          mult_n  = '0;
        end
      SPACE:
        if (phase_end) begin
          cnt_n  = '0;
          mult_n = '0;
          if (left != 3'd0) begin
            load   = 1'b1;
            ld     = code[7:6];
            code_n = {code[7:0], 2'b00};
            left_n = left - 3'd1;
            sym_n  = sym + 3'd1;
          end else begin
            state_n = LGAP;
            units_n = 3'd2;
            skip_n  = 1'b0;
          end
        end
      LGAP:
        if (phase_end) state_n = DONE;
      DONE:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
    if (accept) begin
      sym_n = '0;
      if (lz == 3'd5) begin
        state_n = DONE;
        code_n  = '0;
        left_n  = '0;
      end else begin
        load   = 1'b1;
        ld     = aligned[9:8];
        code_n = aligned;
        left_n = 3'd4 - lz;
      end
    end
    // every symbol load picks its phase and length from the pair
    if (load) begin
      state_n = ld[1] ? MARK : SPACE;
      units_n = (ld == 2'b11) ? 3'd3 :
                (ld == 2'b10) ? 3'd1 : 3'd7;
      skip_n  = (ld == 2'b01);
      cnt_n   = '0;
      mult_n  = '0;
    end
    if (abort && state != IDLE) state_n = IDLE;
    if (state_n == IDLE) begin
      cnt_n   = '0;
      mult_n  = '0;
      units_n = '0;
      skip_n  = 1'b0;
      code_n  = '0;
      left_n  = '0;
      sym_n   = '0;
    end
  end

  // state, counters and registered tone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      mult  <= '0;
      units <= '0;
      skip  <= 1'b0;
      code  <= '0;
      left  <= '0;
      sym   <= '0;
      tone  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mult  <= mult_n;
      units <= units_n;
      skip  <= skip_n;
      code  <= code_n;
      left  <= left_n;
      sym   <= sym_n;
      tone  <= (state_n == MARK);
    end
  end

endmodule

// File: tb/tb_morse_player.sv
// Bench for morse_player: per-cycle trace model from Morse timing rules,
// summary table, abort / reset / back-to-back sequences, random letters.
module tb_morse_player;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] code_in = '0;
  logic       abort = 1'b0;
  logic       ready, tone, done, err;
  logic [2:0] sym_idx;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [9:0] code;
    int         cyc;
    int         hi;
    int         ne;
  } vec_t;

  vec_t tbl[10];

  localparam logic [7:0] IDLE_V = 8'b0000_1000;

  morse_player #(.UNIT_CYCLES(U)) dut (
    .clk(clk), .rst(rst), .start(start), .code_in(code_in),
    .abort(abort), .ready(ready), .tone(tone), .done(done),
    .err(err), .sym_idx(sym_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {1'b0, tone, err, done, ready, sym_idx};
  endfunction

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push(input int n, input logic t, input logic e,
                      input logic d, input logic r, input int s);
    for (int k = 0; k < n; k++)
      exp_q.push_back({1'b0, t, e, d, r, 3'(s)});
  endtask

  // expected outputs for cycles 1..N after acceptance, from timing rules
  task automatic build(input logic [9:0] c);
    int syms[$];
    logic [9:0] tmp;
    exp_q.delete();
    for (int k = 4; k >= 0; k--) begin
      tmp = c >> (2 * k);
      if (syms.size() == 0 && tmp[1:0] == 2'b00) continue;
      syms.push_back(int'(tmp[1:0]));
    end
    foreach (syms[j]) begin
      case (syms[j])
        2: begin push(U, 1, 0, 0, 0, j); push(U, 0, 0, 0, 0, j); end
        3: begin push(3*U, 1, 0, 0, 0, j); push(U, 0, 0, 0, 0, j); end
        0: push(7*U, 0, 0, 0, 0, j);
        default: push(1, 0, 1, 0, 0, j);
      endcase
    end
    if (syms.size() != 0) begin
      push(2*U, 0, 0, 0, 0, syms.size() - 1);
      push(1, 0, 0, 1, 1, syms.size() - 1);
    end else begin
      push(1, 0, 0, 1, 1, 0);
    end
  endtask

  task automatic accept(input logic [9:0] c);
    @(negedge clk);
    check("ready_before_start", outs() & 8'h08, 8'h08);
    start = 1'b1;
    code_in = c;
    @(posedge clk);
  endtask

  task automatic walk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("walk c%0d", i + 1), outs(), exp_q[i]);
    end
  endtask

  task automatic run_trace(input logic [9:0] c, input bit junk,
                           input bit chain, input logic [9:0] nxt,
                           output int cyc, output int hi, output int ne);
    build(c);
    cyc = 0;
    hi = 0;
    ne = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("trace %b c%0d", c, i + 1), outs(), exp_q[i]);
      cyc++;
      hi += int'(tone);
      ne += int'(err);
      if (i == exp_q.size() - 1) begin
        start = chain;
        code_in = nxt;
      end else begin
        start = junk;
        code_in = 10'($urandom);
      end
    end
  endtask

  task automatic quiet(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (outs() !== IDLE_V) bad++;
    end
    check_int(name, bad, 0);
  endtask

  initial begin
    int cyc, hi, ne;
    logic [9:0] c;

    tbl[0] = '{10'b00_00_00_10_11, 33, 16, 0};
    tbl[1] = '{10'b00_00_00_00_00, 1, 0, 0};
    tbl[2] = '{10'b00_00_10_01_10, 26, 8, 1};
    tbl[3] = '{10'b00_00_00_00_10, 17, 4, 0};
    tbl[4] = '{10'b00_00_00_00_11, 25, 12, 0};
    tbl[5] = '{10'b00_00_00_00_01, 10, 0, 1};
    tbl[6] = '{10'b10_00_00_00_00, 129, 4, 0};
    tbl[7] = '{10'b11_11_11_11_11, 89, 60, 0};
    tbl[8] = '{10'b11_01_00_10_01, 63, 16, 2};
    tbl[9] = '{10'b01_01_01_01_01, 14, 0, 5};

    #1 check("reset_outputs", outs(), IDLE_V);
    @(negedge clk);
    rst = 1'b0;
    quiet("idle_after_reset", 3);

    foreach (tbl[v]) begin
      accept(tbl[v].code);
      run_trace(tbl[v].code, 1'b0, 1'b0, 10'd0, cyc, hi, ne);
      check_int($sformatf("len %b", tbl[v].code), cyc, tbl[v].cyc);
      check_int($sformatf("tone %b", tbl[v].code), hi, tbl[v].hi);
      check_int($sformatf("errs %b", tbl[v].code), ne, tbl[v].ne);
      @(negedge clk);
      check($sformatf("idle after %b", tbl[v].code), outs(), IDLE_V);
    end

    // abort on the sixth cycle of a long mark
    build(10'b00_00_00_00_11);
    accept(10'b00_00_00_00_11);
    walk(6);
    abort = 1'b1;
    start = 1'b1;
    code_in = 10'b00_00_00_10_11;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_mark_idle", outs(), IDLE_V);
    quiet("abort_no_done", 40);
    accept(10'b00_00_00_10_11);
    run_trace(10'b00_00_00_10_11, 1'b0, 1'b0, 10'd0, cyc, hi, ne);
    check_int("after_abort_len", cyc, 33);
    @(negedge clk);

    // abort beats start in the DONE cycle
    build(10'b00_00_00_00_10);
    accept(10'b00_00_00_00_10);
    walk(17);
    abort = 1'b1;
    start = 1'b1;
    code_in = 10'b00_00_00_00_11;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_done_idle", outs(), IDLE_V);
    quiet("abort_done_no_accept", 5);

    // asynchronous reset in the second SPACE of 'A'
    build(10'b00_00_00_10_11);
    accept(10'b00_00_00_10_11);
    walk(22);
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", outs(), IDLE_V);
    #1 rst = 1'b0;
    quiet("rst_discards_letter", 40);

    // busy start ignored, start in DONE accepted back-to-back
    accept(10'b00_00_00_10_11);
    run_trace(10'b00_00_00_10_11, 1'b1, 1'b1, 10'b00_00_00_00_11,
              cyc, hi, ne);
    check_int("b2b_first_len", cyc, 33);
    run_trace(10'b00_00_00_00_11, 1'b1, 1'b0, 10'd0, cyc, hi, ne);
    check_int("b2b_second_len", cyc, 25);
    @(negedge clk);
    check("b2b_idle", outs(), IDLE_V);

    // random letters, some with start held while busy
    for (int r = 0; r < 25; r++) begin
      c = 10'($urandom_range(0, 1023));
      accept(c);
      run_trace(c, 1'($urandom_range(0, 1)), 1'b0, 10'd0, cyc, hi, ne);
      @(negedge clk);
      check($sformatf("rand idle %b", c), outs(), IDLE_V);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
